// File: rtl/picorv32_wb_bridge.sv
// PicoRV32 native memory port to pipelined Wishbone single-beat master.
// Slave errors and missing acks complete the CPU transfer and raise sticky flags.
module picorv32_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [3:0]  i_mem_wstrb,
  output logic        o_mem_ready,
  output logic [31:0] o_mem_rdata,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  output logic        o_bus_err,
  output logic        o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          bus_err_q, bus_err_d;
  logic          timeout_q, timeout_d;
  logic          finish;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    ready_d   = 1'b0;
    rdata_d   = rdata_q;
    bus_err_d = bus_err_q;
    timeout_d = timeout_q;
    finish    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_mem_valid) begin
          addr_d  = i_mem_addr;
          data_d  = i_mem_wdata;
          we_d    = |i_mem_wstrb;
          sel_d   = (|i_mem_wstrb) ? i_mem_wstrb : 4'hF;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        if (state_q == S_REQ && !i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end
        // Error outranks a simultaneous ack; timeout only fires when the slave is silent.
        if (i_wb_err) begin
          bus_err_d = 1'b1;
          rdata_d   = ERR_RDATA;
          finish    = 1'b1;
        end else if (i_wb_ack) begin
          rdata_d = we_q ? 32'h0 : i_wb_data;
          finish  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          rdata_d   = ERR_RDATA;
          finish    = 1'b1;
        end
        if (finish) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          ready_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_mem_ready = ready_q;
  assign o_mem_rdata = rdata_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = data_q;
  assign o_wb_sel    = sel_q;
  assign o_wb_we     = we_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_bus_err   = bus_err_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_picorv32_wb_bridge.sv
// Randomized bench for picorv32_wb_bridge: a scheduled Wishbone slave plus a
// word-level memory model give the expected per-cycle handshake and read data.
module tb_picorv32_wb_bridge;

  localparam int T = 8;
  localparam logic [31:0] ERR_RD = 32'hFFFF_FFFF;
  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_TO = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        o_mem_ready;
  logic [31:0] o_mem_rdata, o_wb_addr, o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc, o_wb_stb;
  logic        wb_ack, wb_stall, wb_err;
  logic [31:0] wb_rdata;
  logic        o_bus_err, o_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_bus_err = 1'b0;
  bit exp_to      = 1'b0;

  logic [31:0] ref_mem   [int unsigned];
  logic [31:0] slave_mem [int unsigned];

  always #5 clk = ~clk;

  picorv32_wb_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_mem_valid(mem_valid), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .i_mem_wstrb(mem_wstrb), .o_mem_ready(o_mem_ready), .o_mem_rdata(o_mem_rdata),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_ack(wb_ack), .i_wb_data(wb_rdata), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
    .o_bus_err(o_bus_err), .o_timeout(o_timeout)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (st[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int unsigned k = int'(a[31:2]);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    int unsigned k = int'(a[31:2]);
    return slave_mem.exists(k) ? slave_mem[k] : 32'h0;
  endfunction

  function automatic void preload(input logic [31:0] a, input logic [31:0] v);
    ref_mem[int'(a[31:2])]   = v;
    slave_mem[int'(a[31:2])] = v;
  endfunction

  // One CPU transfer; the slave follows a fixed schedule of stalls, waits and response.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      input int n_stall, input int n_wait, input int mode, input bit keep,
                      input string tag);
    bit          is_wr;
    int          done_c;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_sel;
    logic [2:0]  exp_cs;
    is_wr   = |wstrb;
    done_c  = (mode == M_TO) ? T : 1 + n_stall + n_wait;
    exp_sel = is_wr ? wstrb : 4'hF;
    exp_rdata = (mode == M_ACK) ? (is_wr ? 32'h0 : ref_read(addr)) : ERR_RD;
    if (mode == M_ERR || mode == M_BOTH) exp_bus_err = 1'b1;
    if (mode == M_TO) exp_to = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk); #1;
      wb_stall = (c <= n_stall) && (c <= done_c);
      wb_ack   = (c == done_c) && (mode == M_ACK || mode == M_BOTH);
      wb_err   = (c == done_c) && (mode == M_ERR || mode == M_BOTH);
      wb_rdata = wb_ack ? slave_read(o_wb_addr) : $urandom;
      if (wb_ack && !wb_err && o_wb_we) slave_mem[int'(o_wb_addr[31:2])] =
        merge(slave_read(o_wb_addr), o_wb_data, o_wb_sel);
      exp_cs = {c <= done_c, (c <= done_c) && (c <= n_stall + 1), c == done_c + 1};
      n_checks++;
      if ({o_wb_cyc, o_wb_stb, o_mem_ready} !== exp_cs)
        $display("FAIL %s c%0d cyc/stb/ready got %b want %b", tag, c,
                 {o_wb_cyc, o_wb_stb, o_mem_ready}, exp_cs);
      else n_pass++;
      if (c <= done_c) begin
        n_checks++;
        if ({o_wb_addr, o_wb_data, o_wb_sel, o_wb_we} !== {addr, wdata, exp_sel, is_wr})
          $display("FAIL %s c%0d addr/data/sel/we got %h/%h/%h/%b want %h/%h/%h/%b", tag, c,
                   o_wb_addr, o_wb_data, o_wb_sel, o_wb_we, addr, wdata, exp_sel, is_wr);
        else n_pass++;
      end else begin
        n_checks++;
        if ({o_mem_rdata, o_bus_err, o_timeout} !== {exp_rdata, exp_bus_err, exp_to})
          $display("FAIL %s rdata/bus_err/timeout got %h/%b/%b want %h/%b/%b", tag,
                   o_mem_rdata, o_bus_err, o_timeout, exp_rdata, exp_bus_err, exp_to);
        else n_pass++;
      end
    end
    if (mode == M_ACK && is_wr) ref_mem[int'(addr[31:2])] = merge(ref_read(addr), wdata, wstrb);
    @(posedge clk); #1;
    n_checks++;
    if ({o_wb_cyc, o_wb_stb, o_mem_ready} !== 3'b000)
      $display("FAIL %s idle-after-done cyc/stb/ready got %b want 000", tag,
               {o_wb_cyc, o_wb_stb, o_mem_ready});
    else n_pass++;
    if (!keep) begin
      mem_valid = 1'b0;
      @(posedge clk); #1;
    end
    $display("xfer %-10s addr=%h wstrb=%h stall=%0d wait=%0d mode=%0d rdata=%h", tag, addr,
             wstrb, n_stall, n_wait, mode, o_mem_rdata);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data, o_mem_ready,
         o_mem_rdata, o_bus_err, o_timeout} !== '0)
      $display("FAIL reset outputs got cyc=%b stb=%b ready=%b rdata=%h want all 0",
               o_wb_cyc, o_wb_stb, o_mem_ready, o_mem_rdata);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({o_wb_cyc, o_mem_ready, o_bus_err, o_timeout} !== 4'b0)
      $display("FAIL reset_release got %b want 0000",
               {o_wb_cyc, o_mem_ready, o_bus_err, o_timeout});
    else n_pass++;
    $display("reset done");
  endtask

  task automatic test_led_write();
    logic [31:0] led;
    xfer(32'h8000_0000, 32'h0000_002A, 4'hF, 0, 0, M_ACK, 1'b0, "led_wr");
    led = slave_read(32'h8000_0000);
    n_checks++;
    if (led[5:0] !== 6'h2A) $display("FAIL led_reg got %h want 2a", led[5:0]);
    else n_pass++;
  endtask

  task automatic test_stall_read();
    preload(32'h8000_0004, 32'h0000_003F);
    xfer(32'h8000_0004, $urandom, 4'h0, 3, 2, M_ACK, 1'b0, "stall_rd");
  endtask

  task automatic test_byte_write();
    xfer(32'h8000_0008, $urandom, 4'b0100, 1, 1, M_ACK, 1'b0, "byte_wr");
    xfer(32'h8000_0008, $urandom, 4'h0, 0, 0, M_ACK, 1'b0, "byte_rdbk");
  endtask

  task automatic test_timeout();
    xfer(32'h8000_0010, $urandom, 4'h0, 2, 0, M_TO, 1'b0, "timeout_rd");
    xfer(32'h8000_0014, 32'h1234_5678, 4'hF, 0, 0, M_TO, 1'b0, "timeout_wr");
    xfer(32'h8000_0014, $urandom, 4'h0, 0, 1, M_ACK, 1'b0, "drop_rdbk");
  endtask

  task automatic test_err_ack();
    preload(32'h8000_0018, 32'hCAFE_0001);
    xfer(32'h8000_0018, $urandom, 4'h0, 0, 1, M_BOTH, 1'b0, "err_ack");
    xfer(32'h8000_0018, $urandom, 4'h0, 1, 0, M_ACK, 1'b0, "after_err");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      xfer(32'h8000_0020 + 32'(4 * i), $urandom, (i % 2 == 0) ? 4'hF : 4'h0, 0, 0, M_ACK,
           i != 3, "b2b");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  st;
    int          sel, mode;
    for (int i = 0; i < 24; i++) begin
      a    = 32'h8000_0000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      st   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      sel  = $urandom_range(0, 9);
      mode = (sel < 7) ? M_ACK : (sel == 7) ? M_ERR : (sel == 8) ? M_BOTH : M_TO;
      xfer(a, $urandom, st, $urandom_range(0, 3), $urandom_range(0, 3), mode,
           $urandom_range(0, 1) == 1, "random");
    end
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1;
    mem_addr  = 32'h8000_0004;
    mem_wstrb = 4'h0;
    mem_wdata = $urandom;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
      wb_stall  = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data, o_mem_ready,
         o_mem_rdata, o_bus_err, o_timeout} !== '0)
      $display("FAIL reset_mid outputs got cyc=%b stb=%b addr=%h rdata=%h flags=%b%b want 0",
               o_wb_cyc, o_wb_stb, o_wb_addr, o_mem_rdata, o_bus_err, o_timeout);
    else n_pass++;
    exp_bus_err = 1'b0;
    exp_to      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 1) rst_n = 1'b1;
      n_checks++;
      if ({o_wb_cyc, o_mem_ready} !== 2'b00)
        $display("FAIL reset_mid quiet c%0d cyc/ready got %b want 00", i,
                 {o_wb_cyc, o_mem_ready});
      else n_pass++;
    end
    xfer(32'h8000_0004, $urandom, 4'h0, 1, 1, M_ACK, 1'b0, "post_rst");
  endtask

  task automatic test_late_ack();
    mem_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      wb_ack   = (i < 4) && (i % 2 == 0);
      wb_err   = (i < 4) && (i % 2 == 1);
      wb_rdata = $urandom;
      n_checks++;
      if ({o_wb_cyc, o_wb_stb, o_mem_ready, o_bus_err, o_timeout} !== {3'b000, exp_bus_err, exp_to})
        $display("FAIL late_ack c%0d cyc/stb/ready/err/to got %b want %b", i,
                 {o_wb_cyc, o_wb_stb, o_mem_ready, o_bus_err, o_timeout},
                 {3'b000, exp_bus_err, exp_to});
      else n_pass++;
    end
    $display("late acks ignored check done");
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    wb_ack    = 1'b0;
    wb_err    = 1'b0;
    wb_stall  = 1'b0;
    wb_rdata  = '0;
    test_reset();
    test_led_write();
    test_stall_read();
    test_byte_write();
    test_timeout();
    test_err_ack();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_late_ack();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/picorv32_wb_bridge.md
# picorv32_wb_bridge

Bridge between the PicoRV32 native memory interface and the pipelined Wishbone bus. It is the single Wishbone master that feeds the peripheral slaves, such as the LED register. It converts each native request into one Wishbone single-beat cycle and returns read data with a one-cycle `o_mem_ready` pulse. It also turns slave errors and unresponsive slaves into a completed transfer plus status flags, so the CPU never hangs.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles a transfer may spend in REQ plus WAIT before it is aborted. Legal range 2..65535.
- `ERR_RDATA`, default 32'hFFFF_FFFF: value returned on `o_mem_rdata` for aborted or errored reads.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk` input 1: system clock; all state changes on its rising edge.
- `i_reset_n` input 1: asynchronous active-low reset.
- `i_mem_valid` input 1: CPU request valid.
- `i_mem_addr` input 32: CPU byte address.
- `i_mem_wdata` input 32: CPU write data.
- `i_mem_wstrb` input 4: byte strobes; all zero means read.
- `o_mem_ready` output 1: one-cycle completion pulse.
- `o_mem_rdata` output 32: read data, valid while `o_mem_ready` is high.
- `o_wb_addr` output 32: Wishbone address (byte address, passed through unmodified).
- `o_wb_data` output 32: Wishbone write data.
- `o_wb_sel` output 4: byte selects.
- `o_wb_we` output 1: write enable.
- `o_wb_cyc` output 1: cycle.
- `o_wb_stb` output 1: strobe.
- `i_wb_ack` input 1: slave acknowledge.
- `i_wb_data` input 32: slave read data.
- `i_wb_stall` input 1: slave stall.
- `i_wb_err` input 1: slave error.
- `o_bus_err` output 1: sticky flag, set on `i_wb_err`; cleared only by reset.
- `o_timeout` output 1: sticky flag, set on timeout abort; cleared only by reset.

## Operation
- Four states: IDLE, REQ, WAIT, DONE. All outputs are registered. Only one transfer is outstanding at a time.
- IDLE
  - On `i_mem_valid`=1, latch the request:
    - `o_wb_addr` = `i_mem_addr`
    - `o_wb_data` = `i_mem_wdata`
    - `o_wb_we` = |`i_mem_wstrb`
    - `o_wb_sel` = `i_mem_wstrb` for writes, 4'hF for reads.
  - Set cyc=stb=1, clear the timeout counter, and go to REQ.
- REQ (cyc=1, stb=1)
  - If `i_wb_stall`=0, the strobe is accepted: stb drops next cycle and the state goes to WAIT.
  - A completion event sampled in the same cycle skips WAIT; see completion below.
- WAIT (cyc=1, stb=0): hold until a completion event.
- Completion events, evaluated in REQ and WAIT regardless of stall:
  - Priority is err > ack > timeout.
  - `i_wb_err`: set `o_bus_err`; `o_mem_rdata` = `ERR_RDATA`.
  - `i_wb_ack`: for reads, `o_mem_rdata` = `i_wb_data`; for writes, `o_mem_rdata` = 0.
  - Timeout: the counter equals `TIMEOUT_CYCLES`-1 with no ack/err. Set `o_timeout`; `o_mem_rdata` = `ERR_RDATA`. A write is silently dropped.
  - On any event: cyc=stb=0 and the state goes to DONE.
- DONE
  - `o_mem_ready`=1 for exactly this cycle. `i_mem_valid` is ignored here.
  - Return to IDLE. `o_mem_rdata` holds its value until the next completion.
- Timeout counter
  - Width: $clog2(`TIMEOUT_CYCLES`+1).
  - Increments every cycle spent in REQ or WAIT and saturates; it never wraps.
- Late acks: an `i_wb_ack` or `i_wb_err` arriving in IDLE or DONE is ignored and does not set any flag.
- Reset (asynchronous, usable at any time including mid-transfer):
  - State goes to IDLE.
  - All outputs go to 0: cyc, stb, we, sel, addr, data, `o_mem_ready`, `o_mem_rdata`, `o_bus_err`, `o_timeout`.
  - An in-flight cycle is abandoned; the slave sees cyc drop immediately.

## Timing
- Cycle 0 is the cycle in which `i_mem_valid` is first sampled in IDLE.
- Zero-wait slave (ack combinational on stb, stall=0):
  - cyc/stb high in cycle 1, ack sampled at the end of cycle 1.
  - `o_mem_ready` high in cycle 2, back to IDLE in cycle 3.
  - Total latency 2 cycles, throughput one transfer per 3 cycles.
- Each stall cycle adds 1 cycle of latency. Each WAIT cycle adds 1 cycle of latency.
- Timeout: cyc is high for exactly `TIMEOUT_CYCLES` cycles, then `o_mem_ready` follows in the next cycle.
- stb is high only in REQ. cyc is high only in REQ and WAIT. cyc and `o_mem_ready` are never high together.
- Wishbone outputs are stable while stb=1 and stall=1.

## Test plan
- Write, zero-wait LED slave: wstrb=4'hF, wdata=0x2A, addr=0x8000_0000.
  - Required: cyc/stb/we high in cycle 1 with sel=4'hF; `o_mem_ready` in cycle 2; slave register = 6'h2A; no flags set.
- Read with 3 stall cycles and 2 wait cycles; slave returns 0x0000_003F.
  - Required: `o_mem_ready` in cycle 7 with rdata=0x3F; sel=4'hF; we=0.
- Read where the slave never acks, with `TIMEOUT_CYCLES`=8.
  - Required: cyc high for exactly 8 cycles; `o_mem_ready` in the following cycle with rdata=0xFFFF_FFFF; `o_timeout`=1.
- `i_wb_err` and `i_wb_ack` asserted in the same cycle on a read.
  - Required: rdata=`ERR_RDATA`; `o_bus_err`=1; a following normal read completes with correct data and the flag stays 1.
- `i_reset_n` pulsed low while in WAIT.
  - Required: cyc/stb drop asynchronously; all outputs 0; no `o_mem_ready`; a new request after release completes normally.
- Byte write with wstrb=4'b0100.
  - Required: sel=4'b0100, we=1.
- Back-to-back requests with `i_mem_valid` held high through DONE.
  - Required: the request is not double-issued during DONE.
